// File: rtl/calckit_uart_pkg.sv
// Shared constants for the calculator UART output path: ASCII codes,
// the decimal sender's FSM encoding and its character-pointer phases.
package calckit_uart_pkg;

  localparam logic [7:0] CHAR_MINUS = 8'h2D;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CONV    = 3'd1;
  localparam logic [2:0] ST_EMIT    = 3'd2;
  localparam logic [2:0] ST_WAIT_HI = 3'd3;
  localparam logic [2:0] ST_WAIT_LO = 3'd4;

  // Which part of the message the next character comes from.
  typedef enum logic [2:0] {
    PH_SIGN  = 3'd0,
    PH_DIGIT = 3'd1,
    PH_CR    = 3'd2,
    PH_LF    = 3'd3,
    PH_END   = 3'd4
  } char_phase_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: load captures the binary word, then one
// shift-add-3 step per cycle; valid pulses once the last step has landed.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]          bin_sr;
  logic [CW-1:0]             cnt;
  logic [4*DIGITS-1:0]       bcd_adj;
  logic [4*DIGITS+WIDTH-1:0] shifted;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin_sr} << 1;
  end

  // cnt is a down-counter of remaining iterations; valid fires on terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr <= '0;
      bcd    <= '0;
      cnt    <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (load) begin
        bin_sr <= bin;
        bcd    <= '0;
        cnt    <= CW'(WIDTH);
      end else if (cnt != '0) begin
        bcd    <= shifted[4*DIGITS+WIDTH-1:WIDTH];
        bin_sr <= shifted[WIDTH-1:0];
        cnt    <= cnt - CW'(1);
        valid  <= (cnt == CW'(1));
      end
    end
  end

endmodule

// File: rtl/uart_dec_sender.sv
// Prints a binary result as signed decimal ASCII plus CR LF, one byte at a
// time through the UART transmitter's start/busy handshake.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for send; latches sign and magnitude on accept
// ST_CONV    | binary-to-BCD conversion running
// ST_EMIT    | tx_start pulse is out with the current character
// ST_WAIT_HI | waiting for the transmitter to report busy
// ST_WAIT_LO | waiting for the byte to finish; next char or done
module uart_dec_sender
  import calckit_uart_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] value,
  input  logic             send,
  output logic             busy,
  output logic             done,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [2:0]          state;
  logic                neg_q;
  char_phase_t         phase;
  logic [IW-1:0]       digit_idx;
  logic                seen_nz;

  logic                accept;
  logic                is_neg;
  logic [WIDTH-1:0]    mag;
  logic [4*DIGITS-1:0] bcd;
  logic                bcd_valid;

  char_phase_t         cur_phase;
  char_phase_t         nxt_phase;
  logic [IW-1:0]       msd_idx;
  logic [IW-1:0]       sel_idx;
  logic [IW-1:0]       nxt_idx;
  logic [3:0]          digit;
  logic [7:0]          cur_char;

  // A send in the cycle done is high is deliberately ignored.
  assign accept = (state == ST_IDLE) && send && !busy && !done;
  assign is_neg = (SIGNED != 0) && value[WIDTH-1];
  assign mag    = is_neg ? (~value + WIDTH'(1)) : value;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .bin   (mag),
    .bcd   (bcd),
    .valid (bcd_valid)
  );

  always_comb begin
    msd_idx = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd_idx = IW'(i);
    end
    // Until a digit has gone out, jump straight to the most significant nonzero one.
    sel_idx = seen_nz ? digit_idx : msd_idx;
    digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_idx == IW'(i)) digit = bcd[4*i +: 4];
    end

    cur_phase = (state == ST_CONV) ? (neg_q ? PH_SIGN : PH_DIGIT) : phase;
    cur_char  = CHAR_LF;
    nxt_phase = cur_phase;
    nxt_idx   = digit_idx;
    case (cur_phase)
      PH_SIGN: begin
        cur_char  = CHAR_MINUS;
        nxt_phase = PH_DIGIT;
      end
      PH_DIGIT: begin
        cur_char = CHAR_ZERO + {4'h0, digit};
        if (sel_idx == '0) nxt_phase = PH_CR;
        else               nxt_idx   = sel_idx - IW'(1);
      end
      PH_CR: begin
        cur_char  = CHAR_CR;
        nxt_phase = PH_LF;
      end
      PH_LF: begin
        cur_char  = CHAR_LF;
        nxt_phase = PH_END;
      end
      default: nxt_phase = PH_END;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      neg_q     <= 1'b0;
      phase     <= PH_END;
      digit_idx <= '0;
      seen_nz   <= 1'b0;
    end else begin
      done     <= 1'b0;
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            busy      <= 1'b1;
            neg_q     <= is_neg;
            digit_idx <= IW'(DIGITS - 1);
            seen_nz   <= 1'b0;
            state     <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (bcd_valid) begin
            tx_start  <= 1'b1;
            tx_data   <= cur_char;
            phase     <= nxt_phase;
            digit_idx <= nxt_idx;
            if (cur_phase == PH_DIGIT) seen_nz <= 1'b1;
            state     <= ST_EMIT;
          end
        end
        ST_EMIT: state <= ST_WAIT_HI;
        ST_WAIT_HI: begin
          if (tx_busy) state <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            if (phase == PH_END) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              tx_start  <= 1'b1;
              tx_data   <= cur_char;
              phase     <= nxt_phase;
              digit_idx <= nxt_idx;
              if (cur_phase == PH_DIGIT) seen_nz <= 1'b1;
              state     <= ST_EMIT;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
